// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared defaults, state type and saturation helper for the convolver
package conv_pkg;

  localparam int BW        = 16;
  localparam int FRAC_BIT  = 8;
  localparam int KERN_DIM  = 5;
  localparam int KERN_SIZE = KERN_DIM * KERN_DIM;
  localparam int ACC_W     = 2 * BW + $clog2(KERN_SIZE);
  localparam int SAT_W     = 64;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } conv_state_t;

  // Clamp a sign-extended value into the two's-complement range of a bw-bit word.
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                       input int bw);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) <<< (bw - 1)) - SAT_W'(1);
    lo = -(SAT_W'(1) <<< (bw - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/conv_window_buf.sv
// rtl/conv_window_buf.sv - line-buffer shift register with raster counters and window strobe
module conv_window_buf #(
  parameter int BW       = conv_pkg::BW,
  parameter int KERN_DIM = conv_pkg::KERN_DIM,
  parameter int WIDTH    = 28,
  parameter int HEIGHT   = 28
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic                             shift_en,
  input  logic [BW-1:0]                    pixel,
  output logic [BW*KERN_DIM*KERN_DIM-1:0]  window,
  output logic                             window_valid
);
  import conv_pkg::*;

  localparam int DEPTH = (KERN_DIM - 1) * WIDTH + KERN_DIM;
  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [BW-1:0]    taps [DEPTH];
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             at_window;

  assign at_window = (row >= ROW_W'(KERN_DIM - 1)) && (col >= COL_W'(KERN_DIM - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
      col          <= '0;
      row          <= '0;
      window_valid <= 1'b0;
    end else if (clear) begin
      col          <= '0;
      row          <= '0;
      window_valid <= 1'b0;
    end else begin
      window_valid <= shift_en && at_window;
      if (shift_en) begin
        taps[0] <= pixel;
        for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
        if (col == COL_W'(WIDTH - 1)) begin
          col <= '0;
          row <= (row == ROW_W'(HEIGHT - 1)) ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

  // taps[0] is the newest pixel, i.e. the bottom-right corner of the window.
  for (genvar k = 0; k < KERN_DIM * KERN_DIM; k++) begin : g_win
    localparam int R = k / KERN_DIM;
    localparam int C = k % KERN_DIM;
    assign window[BW*k +: BW] = taps[(KERN_DIM - 1 - R) * WIDTH + (KERN_DIM - 1 - C)];
  end

endmodule

// File: rtl/convolver_complex.sv
// rtl/convolver_complex.sv - streaming KxK convolution with weight load phase and 2-stage MAC
module convolver_complex #(
  parameter int BW       = conv_pkg::BW,
  parameter int FRAC_BIT = conv_pkg::FRAC_BIT,
  parameter int KERN_DIM = conv_pkg::KERN_DIM,
  parameter int WIDTH    = 28,
  parameter int HEIGHT   = 28
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [BW-1:0]                    iPixel,
  input  logic [BW*KERN_DIM*KERN_DIM-1:0]  weights,
  input  logic [BW-1:0]                    bias,
  input  logic                             load_weights,
  output logic                             weight_write,
  output logic [BW-1:0]                    oOut,
  output logic                             oValid
);
  import conv_pkg::*;

  localparam int KERN_SIZE = KERN_DIM * KERN_DIM;
  localparam int ACC_W     = 2 * BW + $clog2(KERN_SIZE);

  conv_state_t state, state_nxt;
  logic                    flush, shift_en;
  logic [BW*KERN_SIZE-1:0] window, w_reg;
  logic [BW-1:0]           b_reg;
  logic                    win_valid, prod_valid;
  logic signed [2*BW-1:0]  prod_nxt [KERN_SIZE];
  logic signed [2*BW-1:0]  prod     [KERN_SIZE];
  logic signed [ACC_W-1:0] acc, scaled;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: state_nxt = ST_RUN;
      ST_RUN:  if (load_weights) state_nxt = ST_LOAD;
      default: state_nxt = ST_LOAD;
    endcase
  end

  // A reload request wins over a pixel arriving in the same cycle.
  always_comb begin
    weight_write = (state == ST_LOAD) && !reset;
    flush        = (state == ST_RUN) && load_weights;
    shift_en     = (state == ST_RUN) && enable && !load_weights;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_reg <= '0;
      b_reg <= '0;
    end else if (weight_write) begin
      w_reg <= weights;
      b_reg <= bias;
    end
  end

  conv_window_buf #(
    .BW       (BW),
    .KERN_DIM (KERN_DIM),
    .WIDTH    (WIDTH),
    .HEIGHT   (HEIGHT)
  ) u_window (
    .clk          (clk),
    .reset        (reset),
    .clear        (flush),
    .shift_en     (shift_en),
    .pixel        (iPixel),
    .window       (window),
    .window_valid (win_valid)
  );

  always_comb begin
    for (int k = 0; k < KERN_SIZE; k++) begin
      prod_nxt[k] = (2*BW)'($signed(window[BW*k +: BW])) * (2*BW)'($signed(w_reg[BW*k +: BW]));
    end
  end

  // Bias is pre-scaled so the single right shift applies to products and bias alike.
  always_comb begin
    acc = ACC_W'($signed(b_reg)) <<< FRAC_BIT;
    for (int k = 0; k < KERN_SIZE; k++) acc = acc + ACC_W'(prod[k]);
    scaled = acc >>> FRAC_BIT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < KERN_SIZE; k++) prod[k] <= '0;
      prod_valid <= 1'b0;
      oValid     <= 1'b0;
      oOut       <= '0;
    end else begin
      for (int k = 0; k < KERN_SIZE; k++) prod[k] <= prod_nxt[k];
      prod_valid <= win_valid && !flush;
      oValid     <= prod_valid && !flush;
      if (prod_valid && !flush) oOut <= BW'(saturate(SAT_W'(scaled), BW));
    end
  end

endmodule

// File: tb/tb_convolver_complex.sv
// tb/tb_convolver_complex.sv - randomized self-checking bench for convolver_complex
module tb_convolver_complex;

  localparam int BW   = 16;
  localparam int FB   = 8;
  localparam int K    = 5;
  localparam int KS   = K * K;
  localparam int W    = 28;
  localparam int H    = 28;
  localparam int NPIX = W * H;

  logic              clk = 1'b0;
  logic              reset, enable, load_weights;
  logic [BW-1:0]     iPixel, bias;
  logic [BW*KS-1:0]  weights;
  logic              weight_write, oValid;
  logic [BW-1:0]     oOut;

  int img [NPIX];
  int wt  [KS];
  int bias_v;
  int got_val[$], got_cyc[$], exp_val[$], exp_cyc[$], ww_cyc[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int first_acc = 0;

  convolver_complex dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .iPixel       (iPixel),
    .weights      (weights),
    .bias         (bias),
    .load_weights (load_weights),
    .weight_write (weight_write),
    .oOut         (oOut),
    .oValid       (oValid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (oValid === 1'b1) begin
      got_val.push_back(int'($signed(oOut)));
      got_cyc.push_back(cyc);
    end
    if (weight_write === 1'b1) ww_cyc.push_back(cyc);
  end

  task automatic pack_weights();
    for (int k = 0; k < KS; k++) weights[BW*k +: BW] = wt[k][BW-1:0];
    bias = bias_v[BW-1:0];
  endtask

  task automatic clear_logs();
    got_val.delete();
    got_cyc.delete();
    exp_cyc.delete();
    ww_cyc.delete();
  endtask

  // Reference: direct sliding-window sum over the stored image, then scale and clamp.
  task automatic compute_ref();
    longint acc;
    exp_val.delete();
    for (int r = 0; r <= H - K; r++) begin
      for (int c = 0; c <= W - K; c++) begin
        acc = longint'(bias_v) * (64'sd1 <<< FB);
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            acc += longint'(img[(r + i) * W + c + j]) * longint'(wt[i * K + j]);
        acc = acc >>> FB;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        exp_val.push_back(int'(acc));
      end
    end
  endtask

  task automatic apply_reset();
    pack_weights();
    reset = 1'b1; enable = 1'b1; load_weights = 1'b0; iPixel = 16'($urandom);
    @(posedge clk); #1;
    clear_logs();
    @(posedge clk); #1;
    reset = 1'b0; iPixel = 16'($urandom);
    @(posedge clk); #1;
    enable = 1'b0;
  endtask

  task automatic do_reload();
    pack_weights();
    load_weights = 1'b1; enable = 1'b1; iPixel = 16'($urandom);
    @(posedge clk); #1;
    clear_logs();
    load_weights = 1'b0; iPixel = 16'($urandom);
    @(posedge clk); #1;
    enable = 1'b0;
  endtask

  task automatic drive_pixels(input int n, input bit gaps, input bit drain);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        enable = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      enable = 1'b1;
      iPixel = 16'(img[i]);
      if ((i / W) >= K - 1 && (i % W) >= K - 1) exp_cyc.push_back(cyc + 3);
      if (i == (K - 1) * W + K - 1) first_acc = cyc + 1;
      @(posedge clk); #1;
    end
    enable = 1'b0;
    if (drain) begin
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ramp();
    for (int i = 0; i < NPIX; i++) img[i] = i;
  endtask

  task automatic set_identity();
    for (int k = 0; k < KS; k++) wt[k] = (k == KS / 2) ? 256 : 0;
    bias_v = 0;
  endtask

  task automatic test_reset();
    weights = '0; bias = '0; load_weights = 1'b0;
    reset = 1'b1; enable = 1'b1; iPixel = 16'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (weight_write !== 1'b0) begin failures++; $display("FAIL reset_ww got=%b exp=0", weight_write); end
    checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", oValid); end
    checks++; if (oOut !== 16'h0) begin failures++; $display("FAIL reset_out got=%h exp=0000", oOut); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (weight_write !== 1'b1) begin failures++; $display("FAIL load_ww got=%b exp=1", weight_write); end
    checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL load_valid got=%b exp=0", oValid); end
    @(posedge clk); #1;
    enable = 1'b0;
    @(negedge clk);
    checks++; if (weight_write !== 1'b0) begin failures++; $display("FAIL run_ww got=%b exp=0", weight_write); end
    @(posedge clk); #1;
  endtask

  task automatic test_ones();
    for (int k = 0; k < KS; k++) wt[k] = 256;
    bias_v = 0;
    for (int i = 0; i < NPIX; i++) img[i] = 256;
    apply_reset();
    checks++; if (ww_cyc.size() != 1) begin failures++; $display("FAIL ones_ww_pulses got=%0d exp=1", ww_cyc.size()); end
    drive_pixels(NPIX, 1'b0, 1'b1);
    compute_ref();
    checks++; if (got_val.size() != 576) begin failures++; $display("FAIL ones_count got=%0d exp=576", got_val.size()); end
    for (int i = 0; i < exp_val.size() && i < got_val.size(); i++) begin
      checks++; if (got_val[i] !== exp_val[i]) begin failures++; $display("FAIL ones_val idx=%0d got=%0d exp=%0d", i, got_val[i], exp_val[i]); end
    end
    if (got_cyc.size() > 0) begin
      checks++; if (got_cyc[0] !== first_acc + 2) begin failures++; $display("FAIL ones_latency got=%0d exp=%0d", got_cyc[0], first_acc + 2); end
    end
  endtask

  task automatic test_identity();
    set_identity();
    set_ramp();
    apply_reset();
    drive_pixels(NPIX, 1'b0, 1'b1);
    checks++; if (got_val.size() != 576) begin failures++; $display("FAIL ident_count got=%0d exp=576", got_val.size()); end
    for (int i = 0; i < got_val.size() && i < 576; i++) begin
      checks++;
      if (got_val[i] !== ((i / 24) + 2) * W + (i % 24) + 2) begin
        failures++; $display("FAIL ident_val idx=%0d got=%0d exp=%0d", i, got_val[i], ((i / 24) + 2) * W + (i % 24) + 2);
      end
    end
  endtask

  task automatic test_bias_sat();
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < KS; k++) wt[k] = (t == 0) ? 0 : (t == 1) ? 256 : -256;
      bias_v = (t == 0) ? 256 : 0;
      for (int i = 0; i < NPIX; i++) img[i] = (t == 0) ? int'($urandom_range(0, 65535)) - 32768 : 32767;
      apply_reset();
      drive_pixels(NPIX, 1'b0, 1'b1);
      compute_ref();
      checks++; if (got_val.size() != exp_val.size()) begin failures++; $display("FAIL sat%0d_count got=%0d exp=%0d", t, got_val.size(), exp_val.size()); end
      for (int i = 0; i < exp_val.size() && i < got_val.size(); i++) begin
        checks++; if (got_val[i] !== exp_val[i]) begin failures++; $display("FAIL sat%0d_val idx=%0d got=%0d exp=%0d", t, i, got_val[i], exp_val[i]); end
      end
    end
  endtask

  task automatic test_gaps();
    set_identity();
    set_ramp();
    apply_reset();
    drive_pixels(NPIX, 1'b1, 1'b1);
    compute_ref();
    checks++; if (got_val.size() != exp_val.size()) begin failures++; $display("FAIL gaps_count got=%0d exp=%0d", got_val.size(), exp_val.size()); end
    for (int i = 0; i < exp_val.size() && i < got_val.size(); i++) begin
      checks++; if (got_val[i] !== exp_val[i]) begin failures++; $display("FAIL gaps_val idx=%0d got=%0d exp=%0d", i, got_val[i], exp_val[i]); end
    end
    for (int i = 0; i < exp_cyc.size() && i < got_cyc.size(); i++) begin
      checks++; if (got_cyc[i] !== exp_cyc[i]) begin failures++; $display("FAIL gaps_cycle idx=%0d got=%0d exp=%0d", i, got_cyc[i], exp_cyc[i]); end
    end
  endtask

  task automatic test_midframe_reset();
    set_identity();
    set_ramp();
    apply_reset();
    drive_pixels(300, 1'b0, 1'b0);
    for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(0, 4095)) - 2048;
    apply_reset();
    checks++; if (ww_cyc.size() != 1) begin failures++; $display("FAIL mid_ww_pulses got=%0d exp=1", ww_cyc.size()); end
    drive_pixels(NPIX, 1'b0, 1'b1);
    compute_ref();
    checks++; if (got_val.size() != 576) begin failures++; $display("FAIL mid_count got=%0d exp=576", got_val.size()); end
    for (int i = 0; i < exp_val.size() && i < got_val.size(); i++) begin
      checks++; if (got_val[i] !== exp_val[i]) begin failures++; $display("FAIL mid_val idx=%0d got=%0d exp=%0d", i, got_val[i], exp_val[i]); end
    end
  endtask

  task automatic test_reload();
    set_identity();
    set_ramp();
    apply_reset();
    drive_pixels(300, 1'b0, 1'b0);
    for (int k = 0; k < KS; k++) wt[k] = int'($urandom_range(0, 512)) - 256;
    bias_v = int'($urandom_range(0, 2048)) - 1024;
    do_reload();
    checks++; if (ww_cyc.size() != 1) begin failures++; $display("FAIL reload_ww_pulses got=%0d exp=1", ww_cyc.size()); end
    drive_pixels(NPIX, 1'b0, 1'b1);
    compute_ref();
    checks++; if (got_val.size() != 576) begin failures++; $display("FAIL reload_count got=%0d exp=576", got_val.size()); end
    for (int i = 0; i < exp_val.size() && i < got_val.size(); i++) begin
      checks++; if (got_val[i] !== exp_val[i]) begin failures++; $display("FAIL reload_val idx=%0d got=%0d exp=%0d", i, got_val[i], exp_val[i]); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < KS; k++) wt[k] = int'($urandom_range(0, 512)) - 256;
    bias_v = int'($urandom_range(0, 8192)) - 4096;
    for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(0, 2047)) - 1024;
    apply_reset();
    drive_pixels(NPIX, 1'b1, 1'b1);
    compute_ref();
    checks++; if (got_val.size() != exp_val.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got_val.size(), exp_val.size()); end
    for (int i = 0; i < exp_val.size() && i < got_val.size(); i++) begin
      checks++; if (got_val[i] !== exp_val[i]) begin failures++; $display("FAIL rand_val idx=%0d got=%0d exp=%0d", i, got_val[i], exp_val[i]); end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; load_weights = 1'b0;
    iPixel = '0; weights = '0; bias = '0; bias_v = 0;
    test_reset();
    test_ones();
    test_identity();
    test_bias_sat();
    test_gaps();
    test_midframe_reset();
    test_reload();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/convolver_complex.md
Name: convolver_complex

Overview:
- Streaming 2-D convolution engine for the neural-accelerator convolution layer.
- Consumes one raster-ordered signed fixed-point pixel per enabled cycle and keeps a sliding KERN_DIM x KERN_DIM window in an internal line-buffer shift register.
- Emits one biased, rescaled, saturated output per valid window position.
- Latches its kernel weights and bias in a load phase, signalled on weight_write, after reset or on request.

Parameters:
- BW, 16: pixel/weight/bias/output word width, signed two's complement.
- FRAC_BIT, 8: fractional bits of all fixed-point words (Q7.8 at default).
- KERN_DIM, 5: kernel side length; KERN_SIZE = KERN_DIM*KERN_DIM (local).
- WIDTH, 28: input image width in pixels.
- HEIGHT, 28: input image height in pixels.

Ports:
- clk  in  1: the single clock; all logic on its rising edge.
- reset  in  1: synchronous, active-high reset.
- enable  in  1: iPixel is valid this cycle.
- iPixel  in  BW: signed input pixel, raster order (row-major, top-left first).
- weights  in  BW*KERN_SIZE: kernel; word k = weights[BW*k +: BW] applies to window row k/KERN_DIM, col k%KERN_DIM (row 0 = oldest/top).
- bias  in  BW: signed bias, same Q format.
- load_weights  in  1: one-cycle request to re-latch weights/bias.
- weight_write  out  1: high for the one cycle in which weights/bias are captured.
- oOut  out  BW: signed convolution result.
- oValid  out  1: oOut valid this cycle.

Behaviour:
- States: LOAD, RUN.
- Reset: state=LOAD; weight_write, oOut, oValid, row/col counters, window registers and pipeline all 0.
- LOAD: lasts exactly one cycle. weight_write=1; internal weight/bias registers capture the weights and bias inputs on that edge. enable is ignored. Next state is RUN.
- RUN: weight_write=0. load_weights=1 moves to LOAD on the next edge, clears counters and oValid pipeline, and discards the partial frame.
- Each RUN cycle with enable=1:
  - shift iPixel into a (KERN_DIM-1)*WIDTH+KERN_DIM deep shift register;
  - advance col (0..WIDTH-1); at col wrap advance row (0..HEIGHT-1);
  - after the last pixel both wrap to 0, and the next frame starts seamlessly.
- enable=0: window and counters hold; the pipeline still advances with bubble (oValid=0).
- Window valid when the accepted pixel has row>=KERN_DIM-1 and col>=KERN_DIM-1. This gives (WIDTH-KERN_DIM+1)*(HEIGHT-KERN_DIM+1) outputs per frame (576 at defaults). No output straddles a row wrap.
- Arithmetic:
  - 25 signed BWxBW products (2*BW bits each);
  - summed at 2*BW+ceil(log2 KERN_SIZE) bits;
  - plus bias sign-extended and shifted left FRAC_BIT;
  - arithmetic right shift by FRAC_BIT (truncation toward -inf);
  - saturate to [-2^(BW-1), 2^(BW-1)-1].
- Latency: stage 1 registers products; stage 2 registers sum/scale/saturate into oOut. oValid and oOut appear 2 cycles after the edge that accepted the window-completing pixel.
- oOut holds its last value when oValid=0.
- Reset mid-frame: everything returns to the reset state, then one LOAD cycle follows.
- Simultaneous load_weights and enable in RUN: reload wins and the pixel is dropped.

Decomposition:
- Package conv_pkg: BW, FRAC_BIT, KERN_DIM, KERN_SIZE defaults; accumulator width constant; saturate function.
- One natural sub-module: conv_window_buf (line-buffer shift register plus row/col counters, exposing the flattened window and a window_valid strobe).
- MAC/scale/saturate pipeline stays in convolver_complex.

Test Plan:
- Reset then release -> weight_write=1 for exactly one cycle, oValid=0; weights all 256 (1.0), bias 0, stream 784 pixels of 256 -> 576 outputs, each 6400 (25.0); first oValid 2 cycles after pixel #117 accepted.
- Identity kernel (center word k=12 =256, others 0), bias 0, pixel value = (row*28+col) -> each output equals the center pixel value (row+2)*28+(col+2).
- Weights 0, bias 0x0100 -> every output 256; weights 256, pixels 0x7FFF -> 32767 (positive saturation); weights 0xFF00 (-1.0), pixels 0x7FFF -> -32768 (negative saturation).
- Random enable gaps (~50% duty) with the ramp image -> same 576 values in the same order as the gap-free run; oValid never high during bubbles except for delayed in-flight results.
- Mid-frame reset after 300 pixels, then a full frame -> exactly 576 outputs with correct values, no stale window data. Repeat with load_weights=1 mid-frame and new weights -> weight_write pulse, then outputs computed with the new weights only.
